// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch next-PC controller.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SRC_MISP = 3'd0,
        SRC_HOLD = 3'd1,
        SRC_JUMP = 3'd2,
        SRC_JR   = 3'd3,
        SRC_BTB  = 3'd4,
        SRC_SEQ  = 3'd5
    } redir_src_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // J-format target: keep the 256 MB region of the delay-slot PC.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] tgt);
        return {pc4[31:28], tgt, 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Bundle between the pipeline (hazard unit, ID, IF/BTB) and the next-PC controller.
// No valid/ready handshake here: every request is a level sampled at each
// posedge; the controller never back-pressures, and its flush_* outputs act in
// the same cycle the request is presented.
interface pc_redirect_ctrl_if;
    import pc_ctrl_pkg::*;

    logic        lu_hazard;
    logic        ex_mispredict;
    logic [31:0] ex_correct_addr;
    logic        id_jump;
    logic        id_jal;
    logic        id_jr;
    logic [25:0] id_target;
    logic [31:0] id_pc4;
    logic [31:0] id_jr_reg;
    logic [31:0] if_pc4;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic [31:0] pc_out;
    logic        if_valid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        ras_empty;
    state_e      state_dbg;
    redir_src_e  src_dbg;

    modport master (
        output lu_hazard, ex_mispredict, ex_correct_addr,
        output id_jump, id_jal, id_jr, id_target, id_pc4, id_jr_reg,
        output if_pc4, btb_taken, btb_target,
        input  pc_out, if_valid, flush_ifid, flush_idex, ras_empty,
        input  state_dbg, src_dbg
    );

    modport slave (
        input  lu_hazard, ex_mispredict, ex_correct_addr,
        input  id_jump, id_jal, id_jr, id_target, id_pc4, id_jr_reg,
        input  if_pc4, btb_taken, btb_target,
        output pc_out, if_valid, flush_ifid, flush_idex, ras_empty,
        output state_dbg, src_dbg
    );

endinterface

// File: rtl/pc_redirect_ctrl_ras.sv
// Return-address stack: circular storage, saturating count, oldest entry lost on overflow.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    // Pop-then-push: with a live pop the top slot is simply rewritten; an
    // empty pop does nothing, so a JALR on an empty stack degrades to a push.
    always_comb begin
        mem_d  = mem_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        do_pop = pop && (cnt_q != '0);
        if (do_pop && push) begin
            mem_d[ptr_q] = push_data;
        end else if (do_pop) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end else if (push) begin
            ptr_d        = ptr_q + PW'(1);
            mem_d[ptr_d] = push_data;
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Stack storage, pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '1;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign top   = mem_q[ptr_q];
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch next-PC controller: boot/run/stall FSM, redirect priority mux, flushes and RAS.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          RAS_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    pc_redirect_ctrl_if.slave bus
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    redir_src_e  src;
    logic        active, accept;
    logic        ras_push, ras_pop, ras_empty;
    logic [31:0] ras_top;

    ras_stack #(.DEPTH(RAS_DEPTH), .W(32)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (bus.id_pc4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // Redirect selection, next state, RAS control and flush lines.
    always_comb begin
        active = (state_q != BOOT);
        accept = active && !bus.lu_hazard && !bus.ex_mispredict;

        src = SRC_HOLD;
        if (active) begin
            if (bus.ex_mispredict)  src = SRC_MISP;
            else if (bus.lu_hazard) src = SRC_HOLD;
            else if (bus.id_jump)   src = SRC_JUMP;
            else if (bus.id_jr)     src = SRC_JR;
            else if (bus.btb_taken) src = SRC_BTB;
            else                    src = SRC_SEQ;
        end

        case (src)
            SRC_MISP: pc_d = bus.ex_correct_addr;
            SRC_JUMP: pc_d = jump_target(bus.id_pc4, bus.id_target);
            SRC_JR:   pc_d = ras_empty ? bus.id_jr_reg : ras_top;
            SRC_BTB:  pc_d = bus.btb_target;
            SRC_SEQ:  pc_d = bus.if_pc4;
            default:  pc_d = pc_q;
        endcase

        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (bus.lu_hazard && !bus.ex_mispredict) state_d = STALL;
            STALL:   if (!bus.lu_hazard || bus.ex_mispredict) state_d = RUN;
            default: state_d = BOOT;
        endcase
        if_valid_d = (state_d != BOOT);

        ras_push = accept && bus.id_jal;
        ras_pop  = accept && bus.id_jr;

        bus.flush_ifid = active && (bus.ex_mispredict ||
                         (!bus.lu_hazard && (bus.id_jump || bus.id_jr)));
        bus.flush_idex = active && bus.ex_mispredict;
    end

    // FSM state and registered fetch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.ras_empty = ras_empty;
    assign bus.state_dbg = state_q;
    assign bus.src_dbg   = src;

endmodule
